instr_encoder: RTL and testbench

- Produces the instruction words that the single-cycle MIPS core's decoder consumes.
- Accepts field-level instruction requests over a valid/ready handshake, packs each one into a 32-bit MIPS word and writes it to instruction memory at consecutive word addresses.
- Used by the bench and boot path to load programs without an external assembler.
- Covers exactly the decoder's instruction subset; anything else is flagged as an error and never written.

---
 rtl/instr_encoder_pkg.sv | 44 ++++
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_encoder_pack.sv | 39 +++
 rtl/instr_encoder.sv | 101 ++++++++++
 tb/tb_instr_encoder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and MIPS field constants for the instruction encoder.
// Selector values, opcodes, R-type function codes and the load FSM states.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        OPS_ADDU  = 4'd0,
        OPS_SUBU  = 4'd1,
        OPS_AND   = 4'd2,
        OPS_OR    = 4'd3,
        OPS_SLTU  = 4'd4,
        OPS_LW    = 4'd5,
        OPS_SW    = 4'd6,
        OPS_BEQ   = 4'd7,
        OPS_ADDIU = 4'd8,
        OPS_J     = 4'd9,
        OPS_LUI   = 4'd10,
        OPS_ORI   = 4'd11,
        OPS_BLTZ  = 4'd12
    } opsel_e;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;
    localparam logic [5:0] OPC_REGIMM = 6'h01;
    localparam logic [5:0] OPC_J      = 6'h02;
    localparam logic [5:0] OPC_BEQ    = 6'h04;
    localparam logic [5:0] OPC_ADDIU  = 6'h09;
    localparam logic [5:0] OPC_ORI    = 6'h0D;
    localparam logic [5:0] OPC_LUI    = 6'h0F;
    localparam logic [5:0] OPC_LW     = 6'h23;
    localparam logic [5:0] OPC_SW     = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_FULL
    } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the instruction encoder.
// The master drives requests; the slave (encoder) drives memory writes and status.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opsel;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              full;
    logic              err;

    modport master (
        output start, in_valid, in_opsel, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, done, full, err
    );

    modport slave (
        input  start, in_valid, in_opsel, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, done, full, err
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: selector plus fields to a 32-bit MIPS word.
// Selectors outside the decoder's subset raise o_illegal and yield a zero word.
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [3:0]  i_opsel,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_word    = '0;
        o_illegal = 1'b0;
        case (opsel_e'(i_opsel))
            OPS_ADDU:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_ADDU};
            OPS_SUBU:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SUBU};
            OPS_AND:   o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_AND};
            OPS_OR:    o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_OR};
            OPS_SLTU:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SLTU};
            OPS_LW:    o_word = {OPC_LW,    i_rs, i_rt, i_imm};
            OPS_SW:    o_word = {OPC_SW,    i_rs, i_rt, i_imm};
            OPS_BEQ:   o_word = {OPC_BEQ,   i_rs, i_rt, i_imm};
            OPS_ADDIU: o_word = {OPC_ADDIU, i_rs, i_rt, i_imm};
            OPS_ORI:   o_word = {OPC_ORI,   i_rs, i_rt, i_imm};
            // LUI has no source register and BLTZ uses rt as a sub-opcode of zero
            OPS_LUI:   o_word = {OPC_LUI,    5'd0, i_rt, i_imm};
            OPS_BLTZ:  o_word = {OPC_REGIMM, i_rs, 5'd0, i_imm};
            OPS_J:     o_word = {OPC_J, i_target};
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes accepted requests and writes them to consecutive
// instruction-memory words starting at BASE_ADDR after each start pulse.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(BASE_ADDR + (1 << ADDR_W) - 1);

    state_e            r_state;
    logic              r_ready;
    logic [ADDR_W-1:0] r_slot;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_full;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_illegal;

    instr_pack u_pack (
        .i_opsel   (bus.in_opsel),
        .i_rs      (bus.in_rs),
        .i_rt      (bus.in_rt),
        .i_rd      (bus.in_rd),
        .i_imm     (bus.in_imm),
        .i_target  (bus.in_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments only; every register,
    // including the pending write, is cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_slot  <= BASE;
            r_we    <= 1'b0;
            r_addr  <= BASE;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.in_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_slot;
                            r_wdata <= w_word;
                            r_slot  <= r_slot + 1'b1;
                        end
                        // in_last takes priority over running out of slots
                        if (bus.in_last) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (!w_illegal && r_slot == LAST_SLOT) begin
                            r_state <= ST_FULL;
                            r_ready <= 1'b0;
                            r_full  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                        r_slot  <= BASE;
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                        r_full  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = r_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.done       = r_done;
    assign bus.full       = r_full;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: a 64-word and a 4-word encoder checked every cycle
// against a spec-level model, plus hand-computed literal expectations.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(6)) if6 ();
    instr_encoder_if #(.ADDR_W(2)) if2 ();

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) u_dut6 (.clk(clk), .reset(rst), .bus(if6));
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (.clk(clk), .reset(rst), .bus(if2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cap [2] = '{64, 4};
    bit          m_run [2] = '{1'b0, 1'b0};
    int          m_cnt [2] = '{0, 0};
    logic        e_we [2] = '{1'b0, 1'b0};
    logic        e_ready [2] = '{1'b0, 1'b0};
    logic        e_done [2] = '{1'b0, 1'b0};
    logic        e_full [2] = '{1'b0, 1'b0};
    logic        e_err [2] = '{1'b0, 1'b0};
    logic [31:0] e_addr [2] = '{32'd0, 32'd0};
    logic [31:0] e_wdata [2] = '{32'd0, 32'd0};

    function automatic logic [31:0] enc(input int sel, input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] rd, input logic [31:0] imm,
                                        input logic [31:0] tgt);
        int funct;
        int op;
        funct = 0;
        op = 0;
        case (sel)
            0: funct = 'h21;
            1: funct = 'h23;
            2: funct = 'h24;
            3: funct = 'h25;
            4: funct = 'h2B;
            5: op = 'h23;
            6: op = 'h2B;
            7: op = 'h04;
            8: op = 'h09;
            11: op = 'h0D;
            default: ;
        endcase
        if (sel <= 4) return (rs << 21) + (rt << 16) + (rd << 11) + funct;
        if (sel == 9) return (32'd2 << 26) + tgt;
        if (sel == 10) return (32'h0F << 26) + (rt << 16) + imm;
        if (sel == 12) return (32'h01 << 26) + (rs << 21) + imm;
        return (op << 26) + (rs << 21) + (rt << 16) + imm;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0; m_cnt[k] = 0;
            e_we[k] = 1'b0; e_ready[k] = 1'b0; e_done[k] = 1'b0; e_full[k] = 1'b0; e_err[k] = 1'b0;
            e_addr[k] = 32'd0; e_wdata[k] = 32'd0;
        end
    endtask

    task automatic model_step(input int k, input logic st, input logic v, input logic [3:0] op,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        bit legal;
        e_we[k] = 1'b0;
        legal = (int'(op) <= 12);
        if (!m_run[k]) begin
            if (st) begin
                m_run[k] = 1'b1; m_cnt[k] = 0;
                e_done[k] = 1'b0; e_full[k] = 1'b0; e_err[k] = 1'b0;
            end
        end else if (v) begin
            if (!legal) begin
                e_err[k] = 1'b1;
            end else begin
                e_we[k] = 1'b1;
                e_addr[k] = m_cnt[k] % cap[k];
                e_wdata[k] = enc(int'(op), 32'(rs), 32'(rt), 32'(rd), 32'(imm), 32'(tgt));
                m_cnt[k]++;
            end
            if (last) begin
                m_run[k] = 1'b0; e_done[k] = 1'b1;
            end else if (legal && m_cnt[k] == cap[k]) begin
                m_run[k] = 1'b0; e_full[k] = 1'b1;
            end
        end
        e_ready[k] = m_run[k];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, if6.start, if6.in_valid, if6.in_opsel, if6.in_rs, if6.in_rt, if6.in_rd,
                       if6.in_imm, if6.in_target, if6.in_last);
            model_step(1, if2.start, if2.in_valid, if2.in_opsel, if2.in_rs, if2.in_rt, if2.in_rd,
                       if2.in_imm, if2.in_target, if2.in_last);
        end
    end

    task automatic compare(input int k, input logic rdy, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic dn, input logic fl, input logic er);
        check($sformatf("m%0d_ready", k), 32'(rdy), 32'(e_ready[k]));
        check($sformatf("m%0d_we", k), 32'(we), 32'(e_we[k]));
        check($sformatf("m%0d_done", k), 32'(dn), 32'(e_done[k]));
        check($sformatf("m%0d_full", k), 32'(fl), 32'(e_full[k]));
        check($sformatf("m%0d_err", k), 32'(er), 32'(e_err[k]));
        if (e_we[k]) begin
            check($sformatf("m%0d_addr", k), addr, e_addr[k]);
            check($sformatf("m%0d_wdata", k), wdata, e_wdata[k]);
        end
    endtask

    always @(negedge clk) begin
        compare(0, if6.in_ready, if6.imem_we, 32'(if6.imem_addr), if6.imem_wdata,
                if6.done, if6.full, if6.err);
        compare(1, if2.in_ready, if2.imem_we, 32'(if2.imem_addr), if2.imem_wdata,
                if2.done, if2.full, if2.err);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int k, input logic st, input logic v, input int op, input int rs,
                         input int rt, input int rd, input int imm, input int tgt, input logic last);
        if (k == 0) begin
            if6.start = st; if6.in_valid = v; if6.in_opsel = 4'(op); if6.in_rs = 5'(rs);
            if6.in_rt = 5'(rt); if6.in_rd = 5'(rd); if6.in_imm = 16'(imm);
            if6.in_target = 26'(tgt); if6.in_last = last;
        end else begin
            if2.start = st; if2.in_valid = v; if2.in_opsel = 4'(op); if2.in_rs = 5'(rs);
            if2.in_rt = 5'(rt); if2.in_rd = 5'(rd); if2.in_imm = 16'(imm);
            if2.in_target = 26'(tgt); if2.in_last = last;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input int k, input int op, input int rs, input int rt, input int rd,
                       input int imm, input int tgt, input logic last);
        drive(k, 1'b0, 1'b1, op, rs, rt, rd, imm, tgt, last);
        cyc();
        drive(k, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_start(input int k);
        drive(k, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        cyc();
        drive(k, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    int ops_left [7] = '{1, 2, 3, 4, 6, 7, 8};

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        drive(1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        cyc();
        cyc();
        check("rst_ready", 32'(if6.in_ready), 32'd0);
        check("rst_we", 32'(if6.imem_we), 32'd0);
        check("rst_addr", 32'(if6.imem_addr), 32'd0);
        check("rst_wdata", if6.imem_wdata, 32'd0);
        check("rst_done", 32'(if6.done), 32'd0);
        check("rst_full", 32'(if6.full), 32'd0);
        check("rst_err", 32'(if6.err), 32'd0);
        rst = 1'b0;
        cyc();

        // single ADDU, terminated with in_last
        do_start(0);
        req(0, 0, 1, 2, 3, 0, 0, 1'b1);
        check("addu_we", 32'(if6.imem_we), 32'd1);
        check("addu_addr", 32'(if6.imem_addr), 32'd0);
        check("addu_word", if6.imem_wdata, 32'h00221821);
        cyc();
        check("addu_done", 32'(if6.done), 32'd1);

        // back-to-back LW then J with in_last
        do_start(0);
        req(0, 5, 29, 8, 0, 'h0004, 0, 1'b0);
        check("lw_addr", 32'(if6.imem_addr), 32'd0);
        check("lw_word", if6.imem_wdata, 32'h8FA80004);
        req(0, 9, 0, 0, 0, 0, 'h10, 1'b1);
        check("j_addr", 32'(if6.imem_addr), 32'd1);
        check("j_word", if6.imem_wdata, 32'h08000010);
        check("j_done", 32'(if6.done), 32'd1);
        check("j_ready", 32'(if6.in_ready), 32'd0);

        // forced-zero fields, illegal selector mid-stream
        do_start(0);
        req(0, 10, 7, 1, 0, 'h1234, 0, 1'b0);
        check("lui_word", if6.imem_wdata, 32'h3C011234);
        req(0, 12, 4, 9, 0, 'hFFFE, 0, 1'b0);
        check("bltz_addr", 32'(if6.imem_addr), 32'd1);
        check("bltz_word", if6.imem_wdata, 32'h0480FFFE);
        req(0, 14, 3, 3, 3, 'h5555, 0, 1'b0);
        check("ill_we", 32'(if6.imem_we), 32'd0);
        check("ill_err", 32'(if6.err), 32'd1);
        req(0, 11, 0, 2, 0, 'h00FF, 0, 1'b0);
        check("ori_addr", 32'(if6.imem_addr), 32'd2);
        check("ori_word", if6.imem_wdata, 32'h340200FF);
        foreach (ops_left[i])
            req(0, ops_left[i], int'($urandom_range(31)), int'($urandom_range(31)),
                int'($urandom_range(31)), int'($urandom_range(65535)), 0, i == 6);
        cyc();

        // asynchronous reset with a write pending
        do_start(0);
        req(0, 0, 5, 6, 7, 0, 0, 1'b0);
        check("pre_rst_we", 32'(if6.imem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_we", 32'(if6.imem_we), 32'd0);
        check("async_rst_ready", 32'(if6.in_ready), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // start together with valid in IDLE: request is not taken
        drive(0, 1'b1, 1'b1, 0, 1, 1, 1, 0, 0, 1'b0);
        cyc();
        drive(0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        check("idle_start_we", 32'(if6.imem_we), 32'd0);
        check("idle_start_ready", 32'(if6.in_ready), 32'd1);
        req(0, 3, 1, 2, 3, 0, 0, 1'b1);
        check("idle_start_first_addr", 32'(if6.imem_addr), 32'd0);
        cyc();

        // 4-word memory: capacity exhaustion
        do_start(1);
        req(1, 15, 1, 1, 1, 1, 0, 1'b0);
        check("small_ill_err", 32'(if2.err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            req(1, 8, 1, 2, 0, i, 0, 1'b0);
            check($sformatf("small_addr%0d", i), 32'(if2.imem_addr), 32'(i));
        end
        check("small_full", 32'(if2.full), 32'd1);
        check("small_full_ready", 32'(if2.in_ready), 32'd0);
        req(1, 8, 1, 2, 0, 9, 0, 1'b0);
        check("small_fifth_we", 32'(if2.imem_we), 32'd0);
        do_start(1);
        check("restart_full", 32'(if2.full), 32'd0);
        check("restart_err", 32'(if2.err), 32'd0);
        req(1, 11, 3, 4, 0, 'h0F0F, 0, 1'b0);
        check("restart_addr", 32'(if2.imem_addr), 32'd0);
        req(1, 2, 1, 2, 3, 0, 0, 1'b0);
        req(1, 4, 1, 2, 3, 0, 0, 1'b0);
        req(1, 6, 1, 2, 0, 8, 0, 1'b1);
        check("last_in_final_slot_addr", 32'(if2.imem_addr), 32'd3);
        check("last_in_final_slot_done", 32'(if2.done), 32'd1);
        check("last_in_final_slot_full", 32'(if2.full), 32'd0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
